// File: rtl/int_issue_queue_pkg.sv
// Shared types for the integer issue queue: dispatched entry, operand, exec-unit payload and CDB.
package int_issue_queue_pkg;

  localparam int XLEN  = 32;
  localparam int TAG_W = 6;

  typedef struct packed {
    logic [XLEN-1:0]  data;
    logic [TAG_W-1:0] tag;
    logic             rdy;
  } operand_t;

  typedef struct packed {
    logic [6:0]       opcode;
    logic [2:0]       func3;
    logic [6:0]       func7;
    logic [TAG_W-1:0] rd_tag;
    operand_t         rs1;
    operand_t         rs2;
  } iq_entry;

  typedef struct packed {
    logic [6:0]       opcode;
    logic [2:0]       func3;
    logic [6:0]       func7;
    logic [XLEN-1:0]  rs1_data;
    logic [XLEN-1:0]  rs2_data;
    logic [TAG_W-1:0] rd_tag;
  } int_fifo_data;

  typedef struct packed {
    logic [TAG_W-1:0] cdb_tag;
    logic [XLEN-1:0]  cdb_result;
    logic             cdb_valid;
    logic             cdb_branch;
    logic             taken;
  } cdb_bfm;

  // A CDB broadcast only produces a result when cdb_valid is set; branch-only cycles never match.
  function automatic logic cdb_hit(input cdb_bfm cdb, input logic [TAG_W-1:0] tag);
    return cdb.cdb_valid && (cdb.cdb_tag == tag);
  endfunction

endpackage

// File: rtl/int_issue_queue_slot.sv
// One source-operand holder: loads on dispatch (with same-cycle CDB bypass) and snoops the CDB
// while its entry is valid and the operand is still waiting.
module iq_operand_slot
  import int_issue_queue_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     load_i,
  input  operand_t load_op_i,
  input  logic     entry_valid_i,
  input  cdb_bfm   cdb_i,
  output operand_t op_o
);

  operand_t op_q;
  operand_t op_d;

  // Next operand state: dispatch load (with bypass) takes precedence over wakeup.
  always_comb begin
    // NOTE: default assignment first so every path assigns op_d and no latch is inferred.
    op_d = op_q;
    if (load_i) begin
      op_d = load_op_i;
      if (!load_op_i.rdy && cdb_hit(cdb_i, load_op_i.tag)) begin
        op_d.data = cdb_i.cdb_result;
        op_d.rdy  = 1'b1;
      end
    end else if (entry_valid_i && !op_q.rdy && cdb_hit(cdb_i, op_q.tag)) begin
      op_d.data = cdb_i.cdb_result;
      op_d.rdy  = 1'b1;
    end
  end

  // Operand register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments in clocked blocks so all registers update from pre-edge values.
    if (!rst_n) op_q <= '0;
    else        op_q <= op_d;
  end

  assign op_o = op_q;

endmodule

// File: rtl/int_issue_queue.sv
// In-order integer issue queue: circular buffer with CDB wakeup; the head requests issue when
// both of its operands are ready and is popped on grant.
module int_issue_queue
  import int_issue_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 6
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_flush,
  input  logic                       i_dispatch_en,
  input  iq_entry                    i_dispatch,
  input  cdb_bfm                     i_cdb,
  input  logic                       issue_granted,
  output logic                       o_issue_req,
  output int_fifo_data               o_int_fifo_data,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [DEPTH-1:0] valid_q, valid_d;

  logic [6:0]       opcode_q [DEPTH];
  logic [2:0]       func3_q  [DEPTH];
  logic [6:0]       func7_q  [DEPTH];
  logic [TAG_W-1:0] rd_tag_q [DEPTH];
  operand_t         rs1      [DEPTH];
  operand_t         rs2      [DEPTH];

  logic push;
  logic pop;
  logic issue_req;

  // The CDB branch-resolution fields belong to the branch unit; the queue only snoops results.
  logic unused_cdb;
  assign unused_cdb = i_cdb.cdb_branch ^ i_cdb.taken;

  assign o_full    = (count_q == FULL_CNT);
  assign o_empty   = (count_q == '0);
  assign o_count   = count_q;
  assign issue_req = valid_q[rd_ptr_q] && rs1[rd_ptr_q].rdy && rs2[rd_ptr_q].rdy;
  assign o_issue_req = issue_req;

  // Full is judged on the registered count, so a slot freed this cycle is not reusable until next.
  assign push = i_dispatch_en && !o_full && !i_flush;
  assign pop  = issue_granted && issue_req && !i_flush;

  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    logic load;
    assign load = push && (wr_ptr_q == PTR_W'(i));

    iq_operand_slot u_rs1 (
      .clk          (clk),
      .rst_n        (rst_n),
      .load_i       (load),
      .load_op_i    (i_dispatch.rs1),
      .entry_valid_i(valid_q[i]),
      .cdb_i        (i_cdb),
      .op_o         (rs1[i])
    );

    iq_operand_slot u_rs2 (
      .clk          (clk),
      .rst_n        (rst_n),
      .load_i       (load),
      .load_op_i    (i_dispatch.rs2),
      .entry_valid_i(valid_q[i]),
      .cdb_i        (i_cdb),
      .op_o         (rs2[i])
    );
  end

  // Pointer, count and valid-bit next state; flush overrides dispatch and issue.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    valid_d  = valid_q;
    if (i_flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      valid_d  = '0;
    end else begin
      if (pop) begin
        valid_d[rd_ptr_q] = 1'b0;
        rd_ptr_d          = rd_ptr_q + PTR_W'(1);
      end
      if (push) begin
        valid_d[wr_ptr_q] = 1'b1;
        wr_ptr_d          = wr_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
    end
  end

  // Per-entry opcode fields and destination tag, written at the dispatch slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: storage is cleared too, so reset mid-operation leaves no stale payload behind.
      for (int i = 0; i < DEPTH; i++) begin
        opcode_q[i] <= '0;
        func3_q[i]  <= '0;
        func7_q[i]  <= '0;
        rd_tag_q[i] <= '0;
      end
    end else if (push) begin
      opcode_q[wr_ptr_q] <= i_dispatch.opcode;
      func3_q[wr_ptr_q]  <= i_dispatch.func3;
      func7_q[wr_ptr_q]  <= i_dispatch.func7;
      rd_tag_q[wr_ptr_q] <= i_dispatch.rd_tag;
    end
  end

  // Head payload to the exec unit, forced to zero unless the head is requesting issue.
  always_comb begin
    o_int_fifo_data = '0;
    if (issue_req) begin
      o_int_fifo_data.opcode   = opcode_q[rd_ptr_q];
      o_int_fifo_data.func3    = func3_q[rd_ptr_q];
      o_int_fifo_data.func7    = func7_q[rd_ptr_q];
      o_int_fifo_data.rs1_data = rs1[rd_ptr_q].data;
      o_int_fifo_data.rs2_data = rs2[rd_ptr_q].data;
      o_int_fifo_data.rd_tag   = rd_tag_q[rd_ptr_q];
    end
  end

  // A dispatch presented while full is dropped; the dispatcher should never do this.
  a_no_dispatch_when_full: assert property (
    @(posedge clk) disable iff (!rst_n) !(i_dispatch_en && o_full && !i_flush)
  ) else $warning("int_issue_queue: dispatch presented while full was dropped");

endmodule

// File: tb/tb_int_issue_queue.sv
// Scoreboard bench for int_issue_queue: stimulus pushes the expected exec payload of every op
// that will issue; a negedge monitor pops and compares whenever a grant meets an issue request.
module tb_int_issue_queue;
  import int_issue_queue_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         i_flush;
  logic         i_dispatch_en;
  iq_entry      i_dispatch;
  cdb_bfm       i_cdb;
  logic         issue_granted;
  logic         o_issue_req;
  int_fifo_data o_int_fifo_data;
  logic         o_full;
  logic         o_empty;
  logic [2:0]   o_count;

  int num_checks = 0;
  int num_errors = 0;
  int_fifo_data exp_q[$];
  int_fifo_data mon_exp;

  always #5 clk = ~clk;

  int_issue_queue #(.DEPTH(4), .TAG_W(6)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_flush        (i_flush),
    .i_dispatch_en  (i_dispatch_en),
    .i_dispatch     (i_dispatch),
    .i_cdb          (i_cdb),
    .issue_granted  (issue_granted),
    .o_issue_req    (o_issue_req),
    .o_int_fifo_data(o_int_fifo_data),
    .o_full         (o_full),
    .o_empty        (o_empty),
    .o_count        (o_count)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    num_checks++;
    if (act !== exp) begin
      num_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic operand_t opnd(input logic [31:0] d, input logic [5:0] t, input logic r);
    operand_t o;
    o.data = d;
    o.tag  = t;
    o.rdy  = r;
    return o;
  endfunction

  function automatic iq_entry mk(input logic [6:0] opc, input logic [2:0] f3, input logic [5:0] rd,
                                 input operand_t a, input operand_t b);
    iq_entry e;
    e.opcode = opc;
    e.func3  = f3;
    e.func7  = 7'h00;
    e.rd_tag = rd;
    e.rs1    = a;
    e.rs2    = b;
    return e;
  endfunction

  function automatic int_fifo_data ex(input logic [6:0] opc, input logic [2:0] f3, input logic [5:0] rd,
                                      input logic [31:0] d1, input logic [31:0] d2);
    int_fifo_data f;
    f.opcode   = opc;
    f.func3    = f3;
    f.func7    = 7'h00;
    f.rs1_data = d1;
    f.rs2_data = d2;
    f.rd_tag   = rd;
    return f;
  endfunction

  function automatic cdb_bfm mkcdb(input logic [5:0] t, input logic [31:0] r, input logic v, input logic br);
    cdb_bfm c;
    c.cdb_tag    = t;
    c.cdb_result = r;
    c.cdb_valid  = v;
    c.cdb_branch = br;
    c.taken      = 1'b0;
    return c;
  endfunction

  // Monitor: every grant that meets an issue request must match the oldest expected payload.
  always @(negedge clk) begin
    if (rst_n && o_issue_req && issue_granted && !i_flush) begin
      num_checks++;
      if (exp_q.size() == 0) begin
        num_errors++;
        $display("FAIL issue_unexpected: got rd_tag %0d, expected no issue", o_int_fifo_data.rd_tag);
      end else begin
        mon_exp = exp_q.pop_front();
        if (o_int_fifo_data !== mon_exp) begin
          num_errors++;
          $display("FAIL issue_payload: got 0x%0h, expected 0x%0h", o_int_fifo_data, mon_exp);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n         = 1'b0;
    i_flush       = 1'b0;
    i_dispatch_en = 1'b0;
    i_dispatch    = '0;
    i_cdb         = '0;
    issue_granted = 1'b0;

    // 1. Reset then idle.
    #12;
    rst_n = 1'b1;
    tick();
    tick();
    check("reset_empty", o_empty, 1'b1);
    check("reset_full", o_full, 1'b0);
    check("reset_req", o_issue_req, 1'b0);
    check("reset_count", o_count, 3'd0);
    check("reset_data", o_int_fifo_data, '0);

    // 2. ADD with both operands ready, granted the cycle after dispatch.
    i_dispatch    = mk(7'h33, 3'd0, 6'd0, opnd(32'd5, 6'd1, 1'b1), opnd(32'd7, 6'd2, 1'b1));
    i_dispatch_en = 1'b1;
    exp_q.push_back(ex(7'h33, 3'd0, 6'd0, 32'd5, 32'd7));
    tick();
    i_dispatch_en = 1'b0;
    check("add_req", o_issue_req, 1'b1);
    check("add_count", o_count, 3'd1);
    check("add_rs1", o_int_fifo_data.rs1_data, 32'd5);
    check("add_rs2", o_int_fifo_data.rs2_data, 32'd7);
    issue_granted = 1'b1;
    tick();
    issue_granted = 1'b0;
    check("add_empty", o_empty, 1'b1);
    check("add_req_gone", o_issue_req, 1'b0);

    // 3. rs2 waits on tag 3; wrong tag and branch-only CDB do not wake; grant without request ignored.
    i_dispatch    = mk(7'h33, 3'd4, 6'd1, opnd(32'h11, 6'd2, 1'b1), opnd(32'h0, 6'd3, 1'b0));
    i_dispatch_en = 1'b1;
    exp_q.push_back(ex(7'h33, 3'd4, 6'd1, 32'h11, 32'h1234));
    tick();
    i_dispatch_en = 1'b0;
    issue_granted = 1'b1;
    check("wait_req0", o_issue_req, 1'b0);
    check("wait_data0", o_int_fifo_data, '0);
    i_cdb = mkcdb(6'd4, 32'hdead, 1'b1, 1'b0);
    tick();
    check("wrong_tag_req", o_issue_req, 1'b0);
    check("nogrant_pop_count", o_count, 3'd1);
    i_cdb = mkcdb(6'd3, 32'hbeef, 1'b0, 1'b1);
    tick();
    check("branch_only_req", o_issue_req, 1'b0);
    i_cdb = mkcdb(6'd3, 32'h1234, 1'b1, 1'b0);
    tick();
    i_cdb = '0;
    check("wake_req", o_issue_req, 1'b1);
    check("wake_rs2", o_int_fifo_data.rs2_data, 32'h1234);
    tick();
    issue_granted = 1'b0;
    check("wake_empty", o_empty, 1'b1);

    // 4. Dispatch bypass: rs1 tag 9 broadcast in the dispatch cycle.
    i_dispatch    = mk(7'h13, 3'd1, 6'd2, opnd(32'h0, 6'd9, 1'b0), opnd(32'h22, 6'd5, 1'b1));
    i_dispatch_en = 1'b1;
    i_cdb         = mkcdb(6'd9, 32'hcafe, 1'b1, 1'b0);
    exp_q.push_back(ex(7'h13, 3'd1, 6'd2, 32'hcafe, 32'h22));
    tick();
    i_dispatch_en = 1'b0;
    i_cdb         = '0;
    check("bypass_req", o_issue_req, 1'b1);
    check("bypass_rs1", o_int_fifo_data.rs1_data, 32'hcafe);
    issue_granted = 1'b1;
    tick();
    issue_granted = 1'b0;

    // Reset mid-operation with a waiting entry queued.
    i_dispatch    = mk(7'h33, 3'd0, 6'd40, opnd(32'h0, 6'd41, 1'b0), opnd(32'h1, 6'd0, 1'b1));
    i_dispatch_en = 1'b1;
    tick();
    i_dispatch_en = 1'b0;
    check("pre_reset_count", o_count, 3'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset_count", o_count, 3'd0);
    check("midreset_empty", o_empty, 1'b1);
    tick();
    rst_n = 1'b1;

    // 5. Fill, drop when full, pop-while-full refuses dispatch, pointers wrap (rd_tags 0..5).
    for (int i = 0; i < 4; i++) begin
      i_dispatch    = mk(7'h33, 3'd0, 6'(i), opnd(32'(100 + i), 6'd0, 1'b1), opnd(32'(200 + i), 6'd0, 1'b1));
      i_dispatch_en = 1'b1;
      exp_q.push_back(ex(7'h33, 3'd0, 6'(i), 32'(100 + i), 32'(200 + i)));
      tick();
    end
    check("fill_full", o_full, 1'b1);
    check("fill_count", o_count, 3'd4);
    i_dispatch = mk(7'h33, 3'd0, 6'd9, opnd(32'd9, 6'd0, 1'b1), opnd(32'd9, 6'd0, 1'b1));
    tick();
    check("drop_count", o_count, 3'd4);
    i_dispatch    = mk(7'h33, 3'd0, 6'd4, opnd(32'd104, 6'd0, 1'b1), opnd(32'd204, 6'd0, 1'b1));
    issue_granted = 1'b1;
    tick();
    check("full_pop_refuse_count", o_count, 3'd3);
    exp_q.push_back(ex(7'h33, 3'd0, 6'd4, 32'd104, 32'd204));
    tick();
    check("pop_push_count", o_count, 3'd3);
    issue_granted = 1'b0;
    i_dispatch    = mk(7'h33, 3'd0, 6'd5, opnd(32'd105, 6'd0, 1'b1), opnd(32'd205, 6'd0, 1'b1));
    exp_q.push_back(ex(7'h33, 3'd0, 6'd5, 32'd105, 32'd205));
    tick();
    i_dispatch_en = 1'b0;
    check("refill_full", o_full, 1'b1);
    issue_granted = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    issue_granted = 1'b0;
    check("drain_empty", o_empty, 1'b1);

    // 6. In-order blocking, then flush with concurrent grant and dispatch.
    i_dispatch_en = 1'b1;
    i_dispatch    = mk(7'h33, 3'd0, 6'd20, opnd(32'h0, 6'd21, 1'b0), opnd(32'h1, 6'd0, 1'b1));
    tick();
    i_dispatch    = mk(7'h33, 3'd0, 6'd21, opnd(32'h2, 6'd0, 1'b1), opnd(32'h3, 6'd0, 1'b1));
    tick();
    i_dispatch    = mk(7'h33, 3'd0, 6'd22, opnd(32'h4, 6'd0, 1'b1), opnd(32'h5, 6'd0, 1'b1));
    tick();
    i_dispatch_en = 1'b0;
    check("inorder_count", o_count, 3'd3);
    check("inorder_block", o_issue_req, 1'b0);
    i_flush       = 1'b1;
    issue_granted = 1'b1;
    i_dispatch_en = 1'b1;
    i_dispatch    = mk(7'h33, 3'd0, 6'd23, opnd(32'h6, 6'd0, 1'b1), opnd(32'h7, 6'd0, 1'b1));
    tick();
    i_flush       = 1'b0;
    issue_granted = 1'b0;
    i_dispatch_en = 1'b0;
    check("flush_count", o_count, 3'd0);
    check("flush_empty", o_empty, 1'b1);
    check("flush_req", o_issue_req, 1'b0);
    i_cdb = mkcdb(6'd21, 32'h77, 1'b1, 1'b0);
    tick();
    i_cdb = '0;
    check("flush_no_wake", o_issue_req, 1'b0);
    i_dispatch    = mk(7'h63, 3'd2, 6'd24, opnd(32'h8, 6'd0, 1'b1), opnd(32'h9, 6'd0, 1'b1));
    i_dispatch_en = 1'b1;
    exp_q.push_back(ex(7'h63, 3'd2, 6'd24, 32'h8, 32'h9));
    tick();
    i_dispatch_en = 1'b0;
    check("post_flush_count", o_count, 3'd1);
    check("post_flush_req", o_issue_req, 1'b1);
    issue_granted = 1'b1;
    tick();
    issue_granted = 1'b0;
    check("final_empty", o_empty, 1'b1);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

endmodule
